// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared word width, access-type encodings and FSM states.
package data_mem_responder_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Unsigned variants exist only for loads.
    function automatic logic type_bad(input logic wen, input logic [2:0] t);
        return t == 3'b011 || t == 3'b110 || t == 3'b111 || (wen && t[2]);
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_unit.sv
// dmem_lane_unit: byte-enable write merge and load lane extract/extend.
module dmem_lane_unit
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]            type_i,
    input  logic [1:0]            lane_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [WORD_WIDTH-1:0] rword_i,
    output logic [WORD_WIDTH-1:0] wword_o,
    output logic [WORD_WIDTH-1:0] rdata_o
);

    logic [3:0]            be;
    logic [WORD_WIDTH-1:0] mask;
    logic [WORD_WIDTH-1:0] wrep;
    logic [7:0]            b;
    logic [15:0]           h;

    // Halfword lanes follow addr[1] only, so addr[0] never shifts a half.
    always_comb begin
        be = type_i[1:0] == 2'b00 ? 4'b0001 << lane_i :
             type_i[1:0] == 2'b01 ? (lane_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wrep = type_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
               type_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
        wword_o = (rword_i & ~mask) | (wrep & mask);
        b = rword_i[{lane_i, 3'b000} +: 8];
        h = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_o = type_i == TYPE_B  ? {{24{b[7]}}, b} :
                  type_i == TYPE_BU ? {24'b0, b} :
                  type_i == TYPE_H  ? {{16{h[15]}}, h} :
                  type_i == TYPE_HU ? {16'b0, h} :
                  type_i == TYPE_W  ? rword_i : '0;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory slave with byte/half/word access.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W instead of forcing alignment.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_type,
    input  logic [WORD_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wen_q;
    logic [2:0]            type_q;
    logic [WORD_WIDTH-1:0] addr_q, wdata_q;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic                  accept, enter_resp, a_wen, a_err, misalign;
    logic [2:0]            a_type;
    logic [WORD_WIDTH-1:0] a_addr, a_wdata, rword, wword, ld;
    logic [IW-1:0]         idx;

    assign accept = req_valid && req_ready;

    // With no wait states RESP is entered on the accepting edge, before the
    // holding registers load, so the live request is used while in IDLE.
    always_comb begin
        a_wen   = state_q == ST_IDLE ? req_wen   : wen_q;
        a_type  = state_q == ST_IDLE ? req_type  : type_q;
        a_addr  = state_q == ST_IDLE ? req_addr  : addr_q;
        a_wdata = state_q == ST_IDLE ? req_wdata : wdata_q;
        idx     = a_addr[IW+1:2];
        rword   = mem_q[idx];
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (a_type[1:0] == 2'b01 && a_addr[0]) || (a_type == TYPE_W && a_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        a_err = (a_addr >> (IW + 2)) != '0 || type_bad(a_wen, a_type) || misalign;
    end

    dmem_lane_unit u_lane (
        .type_i  (a_type),
        .lane_i  (a_addr[1:0]),
        .wdata_i (a_wdata),
        .rword_i (rword),
        .wword_o (wword),
        .rdata_o (ld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wen_q   <= req_wen;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: if (accept) begin
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = WAIT_CYCLES == 0 ? ST_RESP : ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? ST_RESP : ST_BUSY;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        enter_resp = state_d == ST_RESP && state_q != ST_RESP;
        rdata_d    = enter_resp && !a_wen && !a_err ? ld : '0;
        err_d      = enter_resp && a_err;
    end

    always_comb begin
        req_ready = state_q == ST_IDLE && !rst;
        rsp_valid = state_q == ST_RESP;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && a_wen && !a_err) mem_q[idx] <= wword;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed accesses checked against a byte-array model.
module tb_data_mem_responder;

    localparam int WAIT = 2;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0, req_wen = 0;
    logic [2:0]  req_type = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        rst0 = 1;
    logic        req_valid0 = 0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_chk = 0, n_pass = 0;
    logic [7:0] ref_b [4096];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_wen(1'b0), .req_type(3'b010), .req_addr(32'h0), .req_wdata(32'h0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Memory as a byte array: accesses round down to their size, loads extend.
    task automatic model(input logic wen, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
        int sz, base;
        logic [31:0] v;
        sz = t[1:0] == 2'd0 ? 1 : t[1:0] == 2'd1 ? 2 : 4;
        er = a >= 32'd4096 || t == 3'd3 || t >= 3'd6 || (wen && t[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        er = er || (a & 32'(sz - 1)) != 0;
`endif
        rd = 0;
        if (!er) begin
            base = int'(a) & ~(sz - 1);
            v = 0;
            for (int k = 0; k < sz; k++)
                if (wen) ref_b[base + k] = d[8*k +: 8];
                else v = v | (32'(ref_b[base + k]) << (8 * k));
            if (!wen && !t[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8 * sz));
            rd = v;
        end
    endtask

    // Called at a negedge; returns at the negedge after the response cycle.
    task automatic access(input logic wen, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat, output logic bad);
        int n;
        req_valid = 1; req_wen = wen; req_type = t; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 0; req_wen = 1'($urandom); req_type = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; bad = 0; rd = 0; er = 0;
        do begin
            @(negedge clk); lat++;
            if (!rsp_valid && (rsp_rdata != 0 || rsp_err)) bad = 1;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata; er = rsp_err;
        @(negedge clk);
        if (rsp_valid || rsp_rdata != 0 || rsp_err) bad = 1;
    endtask

    task automatic xfer(input string tag, input logic wen, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic fixed, input logic [31:0] xrd, input logic xer);
        logic [31:0] mrd, rd;
        logic mer, er, bad;
        int lat;
        model(wen, t, a, d, mrd, mer);
        access(wen, t, a, d, rd, er, lat, bad);
        chk({tag, "_rdata"}, rd, fixed ? xrd : mrd);
        chk({tag, "_err"}, 32'(er), 32'(fixed ? xer : mer));
        chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
        chk({tag, "_quiet"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [2:0] t;
        logic [31:0] a;
        logic [2:0] tl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++) xfer("init", 1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0, 0, 0);

        xfer("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        xfer("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        xfer("sb13", 1'b1, 3'd0, 32'h13, 32'h000000F0, 1'b1, 32'h0, 1'b0);
        xfer("lb13", 1'b0, 3'd0, 32'h13, 32'h0, 1'b1, 32'hFFFFFFF0, 1'b0);
        xfer("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 1'b1, 32'h000000F0, 1'b0);
        xfer("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hF0ADBEEF, 1'b0);
        xfer("lh12", 1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 32'hFFFFF0AD, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        xfer("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
`else
        xfer("lh11", 1'b0, 3'd1, 32'h11, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0);
`endif
        xfer("sw1000", 1'b1, 3'd2, 32'h1000, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
        xfer("lw0", 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 0, 0);
        xfer("sbu_bad", 1'b1, 3'd4, 32'h8, 32'h55, 1'b1, 32'h0, 1'b1);
        xfer("type3", 1'b0, 3'd3, 32'h8, 32'h0, 1'b1, 32'h0, 1'b1);

        req_valid = 1; req_wen = 1; req_type = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 0; rst = 1;
        @(negedge clk);
        chk("rstbusy_ready", 32'(req_ready), 32'd0);
        chk("rstbusy_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rstfall_ready", 32'(req_ready), 32'd1);
        begin
            logic seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
            end
            chk("rstbusy_noresp", 32'(seen), 32'd0);
        end
        xfer("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            t = $urandom_range(0, 9) == 0 ? 3'($urandom) : tl[$urandom_range(0, 4)];
            a = $urandom_range(0, 9) == 0 ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
            xfer("rnd", 1'($urandom), t, a, $urandom, 1'b0, 0, 0);
        end

        rst0 = 0; req_valid0 = 1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            else #1;
            chk("w0_ready", 32'(req_ready0), 32'(k % 2 == 0));
            chk("w0_valid", 32'(rsp_valid0), 32'(k % 2 == 1));
        end
        req_valid0 = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
